bcd_display_scanner: RTL and testbench

- Downstream consumer of the 3-digit packed BCD incrementor output ({hundreds, tens, units}, 4 bits each).
- Captures a BCD value on a load strobe and holds it in a shadow register.
- Commits the shadowed value to the display register only at a frame boundary, so the display never tears.
- Time-multiplexes the three digits onto one active-low 7-segment bus with per-digit anode select, leading-zero blanking and an invalid-digit indication.

---
 rtl/bcd_display_scanner_pkg.sv | 29 ++
 rtl/bcd_display_scanner_bcd_to_seg7.sv | 32 +++
 rtl/bcd_display_scanner.sv | 98 +++++++++
 tb/tb_bcd_display_scanner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the packed 3-digit BCD path and its 7-segment display.
// Digit field positions are common to the incrementor, the scanner and benches.
package bcd_display_scanner_pkg;

   localparam int BCD_W = 4;

   localparam int UNITS_LSB = 0;
   localparam int TENS_LSB  = 4;
   localparam int HUNDS_LSB = 8;

   localparam logic [1:0] DIG_UNITS = 2'd0;
   localparam logic [1:0] DIG_TENS  = 2'd1;
   localparam logic [1:0] DIG_HUNDS = 2'd2;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// One BCD nibble to an active-low 7-segment pattern.
// Non-decimal nibbles show a dash so a corrupt digit is visible.
module bcd_to_seg7
   import bcd_display_scanner_pkg::*;
(
   input  logic [BCD_W-1:0] nib,
   input  logic             blank,
   output logic [6:0]       seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Shadow-buffered, frame-synchronous scanner for a 3-digit 7-segment display.
// Loaded values reach the display only when the digit index wraps to 0.
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] bcd_in,
   input  logic        load,
   input  logic        lz_en,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        frame_start,
   output logic        pending
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]    cnt;
   logic [1:0]       idx;
   logic [11:0]      shadow;
   logic [11:0]      disp;
   logic             tc;
   logic             wrap;
   logic [BCD_W-1:0] hund;
   logic [BCD_W-1:0] tens;
   logic [BCD_W-1:0] nib;
   logic             blank;
   logic [6:0]       seg_next;

   assign tc   = (cnt == CW'(REFRESH_DIV - 1));
   assign wrap = tc && (idx == 2'(DIGITS - 1));
   assign hund = disp[HUNDS_LSB +: BCD_W];
   assign tens = disp[TENS_LSB +: BCD_W];

   // Only an exact zero blanks; an invalid nibble still shows its dash.
   always_comb begin
      nib   = disp[UNITS_LSB +: BCD_W];
      blank = 1'b0;
      unique case (1'b1)
         (idx == DIG_TENS): begin
            nib   = tens;
            blank = lz_en && (hund == 4'd0) && (tens == 4'd0);
         end
         (idx == DIG_HUNDS): begin
            nib   = hund;
            blank = lz_en && (hund == 4'd0);
         end
         default: begin
            nib   = disp[UNITS_LSB +: BCD_W];
            blank = 1'b0;
         end
      endcase
   end

   bcd_to_seg7 u_dec (
      .nib   (nib),
      .blank (blank),
      .seg   (seg_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= DIG_UNITS;
         shadow      <= '0;
         disp        <= '0;
         pending     <= 1'b0;
         seg         <= SEG_BLANK;
         an          <= 3'b111;
         frame_start <= 1'b0;
      end else begin
         cnt <= tc ? '0 : cnt + 1'b1;
         if (tc) begin
            idx <= wrap ? DIG_UNITS : idx + 2'd1;
         end
         if (load) begin
            shadow <= bcd_in;
         end
         // Commit uses the pre-edge shadow; a coincident load waits a frame.
         if (wrap && pending) begin
            disp <= shadow;
         end
         if (load) begin
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
         seg         <= seg_next;
         an          <= ~(3'b001 << idx);
         frame_start <= (cnt == '0) && (idx == DIG_UNITS);
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: driver queues hand-computed per-cycle outputs,
// monitor pops and compares one entry after every rising edge.
module tb_bcd_display_scanner;

   typedef struct {
      logic [6:0] seg;
      logic [2:0] an;
      logic       fs;
      logic       pend;
      int         tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] bcd_in = '0;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        frame_start;
   logic        pending;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step = 0;
   logic lz_cur = 1'b0;

   always #5 clk = ~clk;

   bcd_display_scanner #(
      .DIGITS      (3),
      .REFRESH_DIV (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bcd_in      (bcd_in),
      .load        (load),
      .lz_en       (lz_en),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start),
      .pending     (pending)
   );

   task automatic drive(input logic rst, input logic ld,
                        input logic [11:0] b, input logic [6:0] es,
                        input logic [2:0] ea, input logic ef,
                        input logic ep);
      exp_t e;
      @(negedge clk);
      reset  = rst;
      load   = ld;
      bcd_in = b;
      lz_en  = lz_cur;
      e.seg  = es;
      e.an   = ea;
      e.fs   = ef;
      e.pend = ep;
      e.tag  = step;
      step++;
      q.push_back(e);
   endtask

   task automatic cyc(input int n, input logic ld, input logic [11:0] b,
                      input logic [6:0] es, input logic [2:0] ea,
                      input logic ef, input logic ep);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, ld && (i == 0), b, es, ea, ef && (i == 0), ep);
      end
   endtask

   task automatic rst_cyc(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b0, 12'h000, 7'h7F, 3'b111, 1'b0, 1'b0);
      end
   endtask

   // Monitor: every cycle is an output beat once the driver has queued one.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (seg !== e.seg || an !== e.an ||
                frame_start !== e.fs || pending !== e.pend) begin
               n_bad++;
               $display("FAIL step%0d: got seg=%h an=%b fs=%b pend=%b, want seg=%h an=%b fs=%b pend=%b",
                        e.tag, seg, an, frame_start, pending,
                        e.seg, e.an, e.fs, e.pend);
            end
         end
      end
   end

   initial begin
      int guard;

      // Reset, then two idle frames of 000 with blanking off
      rst_cyc(2);
      lz_cur = 1'b0;
      for (int f = 0; f < 2; f++) begin
         cyc(4, 0, 12'h000, 7'h40, 3'b110, 1, 0);
         cyc(4, 0, 12'h000, 7'h40, 3'b101, 0, 0);
         cyc(4, 0, 12'h000, 7'h40, 3'b011, 0, 0);
      end

      // Load 095 mid-frame with blanking on
      lz_cur = 1'b1;
      cyc(4, 0, 12'h000, 7'h40, 3'b110, 1, 0);
      cyc(1, 1, 12'h095, 7'h7F, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h7F, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h7F, 3'b011, 0, 1);
      cyc(1, 0, 12'h000, 7'h7F, 3'b011, 0, 0);
      cyc(4, 0, 12'h000, 7'h12, 3'b110, 1, 0);
      cyc(4, 0, 12'h000, 7'h10, 3'b101, 0, 0);
      cyc(4, 0, 12'h000, 7'h7F, 3'b011, 0, 0);

      // 123 then 456 in one frame; last load wins
      cyc(1, 0, 12'h000, 7'h12, 3'b110, 1, 0);
      cyc(1, 1, 12'h123, 7'h12, 3'b110, 0, 1);
      cyc(2, 0, 12'h000, 7'h12, 3'b110, 0, 1);
      cyc(1, 1, 12'h456, 7'h10, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h10, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h7F, 3'b011, 0, 1);
      cyc(1, 0, 12'h000, 7'h7F, 3'b011, 0, 0);

      // Frame showing 456; load 111, then 007 on the wrap edge
      cyc(1, 1, 12'h111, 7'h02, 3'b110, 1, 1);
      cyc(3, 0, 12'h000, 7'h02, 3'b110, 0, 1);
      cyc(4, 0, 12'h000, 7'h12, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h19, 3'b011, 0, 1);
      cyc(1, 1, 12'h007, 7'h19, 3'b011, 0, 1);
      cyc(4, 0, 12'h000, 7'h79, 3'b110, 1, 1);
      cyc(4, 0, 12'h000, 7'h79, 3'b101, 0, 1);
      cyc(3, 0, 12'h000, 7'h79, 3'b011, 0, 1);
      cyc(1, 0, 12'h000, 7'h79, 3'b011, 0, 0);

      // Frame showing 007; load 0A0 during the hundreds slot
      cyc(4, 0, 12'h000, 7'h78, 3'b110, 1, 0);
      cyc(4, 0, 12'h000, 7'h7F, 3'b101, 0, 0);
      cyc(1, 1, 12'h0A0, 7'h7F, 3'b011, 0, 1);
      cyc(2, 0, 12'h000, 7'h7F, 3'b011, 0, 1);
      cyc(1, 0, 12'h000, 7'h7F, 3'b011, 0, 0);
      cyc(4, 0, 12'h000, 7'h40, 3'b110, 1, 0);
      cyc(4, 0, 12'h000, 7'h3F, 3'b101, 0, 0);
      cyc(4, 0, 12'h000, 7'h7F, 3'b011, 0, 0);

      // Load 987, then reset mid-slot; 987 must never appear
      cyc(1, 1, 12'h987, 7'h40, 3'b110, 1, 1);
      cyc(3, 0, 12'h000, 7'h40, 3'b110, 0, 1);
      cyc(1, 0, 12'h000, 7'h3F, 3'b101, 0, 1);
      rst_cyc(2);
      lz_cur = 1'b0;
      for (int f = 0; f < 2; f++) begin
         cyc(4, 0, 12'h000, 7'h40, 3'b110, 1, 0);
         cyc(4, 0, 12'h000, 7'h40, 3'b101, 0, 0);
         cyc(4, 0, 12'h000, 7'h40, 3'b011, 0, 0);
      end

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         #3;
         guard++;
      end
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
